lcd_bus_responder: RTL and testbench

//  Receiving end of the 8-bit HD44780-style LCD bus (LCD_DATA/RS/RW/EN) driven by our LCD controller.
//  - Decodes instruction and data writes; keeps a 32-char shadow DDRAM (2x16) plus cursor/display state.
//  - Used as a synthesizable LCD mirror (VGA/UART readout of panel contents) and as the bench responder
//    for LCD sequencer tests.
//  - Never drives the bus.

---
 rtl/lcd_bus_responder.sv | 207 ++++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_responder.sv
// Shadow responder for an 8-bit HD44780-style LCD bus: mirrors DDRAM and cursor state.
// Optional macro LCD_RESP_BUSY_EN adds a WAIT state modelling the panel's busy time.
module lcd_bus_responder #(
    parameter int BUSY_CYC  = 2000,
    parameter int CLEAR_CYC = 82000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] LCD_DATA,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_EN,
    input  logic [4:0] iRD_ADDR,
    output logic [7:0] oRD_CHAR,
    output logic [4:0] oCURSOR,
    output logic       oDISP_ON,
    output logic       oBUSY,
    output logic       oEVT,
    output logic       oEVT_RS,
    output logic [7:0] oEVT_DATA,
    output logic       oERR
);

    if (CLEAR_CYC < 32 || BUSY_CYC < 0) begin : gBadCfg
        $error("lcd_bus_responder: CLEAR_CYC must be >= 32 and BUSY_CYC >= 0");
    end

`ifdef LCD_RESP_BUSY_EN
    typedef enum logic [1:0] {INIT, IDLE, CLEAR, WAIT} stateT;

    localparam int MaxCyc = (BUSY_CYC > CLEAR_CYC) ? BUSY_CYC : CLEAR_CYC;
    localparam int CW = $clog2(MaxCyc + 1);
    localparam bit BusyWait = BUSY_CYC > 0;
    localparam bit ClearWait = CLEAR_CYC > 32;
    localparam logic [CW-1:0] BusyLoad = BusyWait ? CW'(BUSY_CYC - 1) : '0;
    localparam logic [CW-1:0] ClearLoad = ClearWait ? CW'(CLEAR_CYC - 33) : '0;

    logic [CW-1:0] waitCnt;
    logic [CW-1:0] waitNext;
`else
    typedef enum logic [1:0] {INIT, IDLE, CLEAR} stateT;
`endif

    stateT       state;
    stateT       stateNext;
    logic [4:0]  fillCnt;
    logic [4:0]  fillNext;
    logic [4:0]  cursorNext;
    logic        incDir;
    logic        incNext;
    logic        dispNext;

    logic [1:0]  enSync;
    logic [1:0]  rsSync;
    logic [1:0]  rwSync;
    logic [7:0]  dataSync0;
    logic [7:0]  dataSync1;
    logic        enPrev;

    logic        busRs;
    logic        busRw;
    logic [7:0]  busD;
    logic        writeEdge;
    logic        accept;
    logic        drop;

    logic        memWe;
    logic [4:0]  memAddr;
    logic [7:0]  memWd;
    logic [7:0]  ddram [32];

    assign busRs = rsSync[1];
    assign busRw = rwSync[1];
    assign busD = dataSync1;
    assign writeEdge = enPrev & ~enSync[1] & ~busRw;
    assign accept = writeEdge & (state == IDLE);
    assign drop = writeEdge & (state != IDLE);

    always_comb begin
        stateNext = state;
        fillNext = fillCnt;
        cursorNext = oCURSOR;
        incNext = incDir;
        dispNext = oDISP_ON;
        memWe = 1'b0;
        memAddr = fillCnt;
        memWd = 8'h20;
`ifdef LCD_RESP_BUSY_EN
        waitNext = waitCnt;
`endif
        unique case (state)
            INIT, CLEAR: begin
                memWe = 1'b1;
                fillNext = fillCnt + 5'd1;
                if (fillCnt == 5'd31) begin
                    stateNext = IDLE;
`ifdef LCD_RESP_BUSY_EN
                    if (state == CLEAR && ClearWait) begin
                        stateNext = WAIT;
                        waitNext = ClearLoad;
                    end
`endif
                end
            end
            IDLE: begin
                if (accept) begin
`ifdef LCD_RESP_BUSY_EN
                    if (BusyWait) begin
                        stateNext = WAIT;
                        waitNext = BusyLoad;
                    end
`endif
                    if (busRs) begin
                        memWe = 1'b1;
                        memAddr = oCURSOR;
                        memWd = busD;
                        cursorNext = incDir ? oCURSOR + 5'd1 : oCURSOR - 5'd1;
                    end else begin
                        // Highest set bit selects the instruction
                        priority case (1'b1)
                            busD[7]: cursorNext = {busD[6], busD[3:0]};
                            busD[6], busD[5], busD[4]: ;
                            busD[3]: dispNext = busD[2];
                            busD[2]: incNext = busD[1];
                            busD[1]: cursorNext = '0;
                            busD[0]: begin
                                cursorNext = '0;
                                incNext = 1'b1;
                                fillNext = '0;
                                stateNext = CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
`ifdef LCD_RESP_BUSY_EN
            WAIT: begin
                if (waitCnt == '0) begin
                    stateNext = IDLE;
                end else begin
                    waitNext = waitCnt - 1'b1;
                end
            end
`endif
            default: stateNext = INIT;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            enSync <= '0;
            rsSync <= '0;
            rwSync <= '0;
            dataSync0 <= '0;
            dataSync1 <= '0;
            enPrev <= 1'b0;
            state <= INIT;
            fillCnt <= '0;
            oCURSOR <= '0;
            incDir <= 1'b1;
            oDISP_ON <= 1'b0;
            oBUSY <= 1'b0;
            oEVT <= 1'b0;
            oEVT_RS <= 1'b0;
            oEVT_DATA <= '0;
            oERR <= 1'b0;
            oRD_CHAR <= '0;
`ifdef LCD_RESP_BUSY_EN
            waitCnt <= '0;
`endif
        end else begin
            enSync <= {enSync[0], LCD_EN};
            rsSync <= {rsSync[0], LCD_RS};
            rwSync <= {rwSync[0], LCD_RW};
            dataSync0 <= LCD_DATA;
            dataSync1 <= dataSync0;
            enPrev <= enSync[1];
            state <= stateNext;
            fillCnt <= fillNext;
            oCURSOR <= cursorNext;
            incDir <= incNext;
            oDISP_ON <= dispNext;
            oBUSY <= (stateNext != IDLE);
            oEVT <= accept;
            if (accept) begin
                oEVT_RS <= busRs;
                oEVT_DATA <= busD;
            end
            if (drop) begin
                oERR <= 1'b1;
            end
            // Nonblocking read of the array gives read-first on collisions
            oRD_CHAR <= ddram[iRD_ADDR];
`ifdef LCD_RESP_BUSY_EN
            waitCnt <= waitNext;
`endif
        end
    end

    always_ff @(posedge iCLK) begin
        if (memWe) begin
            ddram[memAddr] <= memWd;
        end
    end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Randomized bench for lcd_bus_responder against a behavioural panel model.
module tb_lcd_bus_responder;

`ifdef LCD_RESP_BUSY_EN
    localparam int GAP = 110;
    localparam int CGAP = 210;
`else
    localparam int GAP = 6;
    localparam int CGAP = 40;
`endif

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b1;
    logic [7:0] LCD_DATA = '0;
    logic       LCD_RS = 1'b0;
    logic       LCD_RW = 1'b0;
    logic       LCD_EN = 1'b0;
    logic [4:0] iRD_ADDR = '0;
    logic [7:0] oRD_CHAR;
    logic [4:0] oCURSOR;
    logic       oDISP_ON;
    logic       oBUSY;
    logic       oEVT;
    logic       oEVT_RS;
    logic [7:0] oEVT_DATA;
    logic       oERR;

    int checks = 0;
    int failures = 0;

    logic [7:0] mdlMem [32];
    int         mdlCur;
    bit         mdlInc;
    bit         mdlDisp;
    bit         mdlErr;
    int         mdlEvt = 0;

    int         evtCnt = 0;
    logic       lastRs;
    logic [7:0] lastData;
    logic [7:0] rdVals [32];

    lcd_bus_responder #(
        .BUSY_CYC(100),
        .CLEAR_CYC(200)
    ) dut (
        .iCLK(iCLK),
        .iRST_N(iRST_N),
        .LCD_DATA(LCD_DATA),
        .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN),
        .iRD_ADDR(iRD_ADDR),
        .oRD_CHAR(oRD_CHAR),
        .oCURSOR(oCURSOR),
        .oDISP_ON(oDISP_ON),
        .oBUSY(oBUSY),
        .oEVT(oEVT),
        .oEVT_RS(oEVT_RS),
        .oEVT_DATA(oEVT_DATA),
        .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    always @(negedge iCLK) begin
        if (oEVT === 1'b1) begin
            evtCnt++;
            lastRs = oEVT_RS;
            lastData = oEVT_DATA;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic mdlReset();
        for (int a = 0; a < 32; a++) mdlMem[a] = 8'h20;
        mdlCur = 0;
        mdlInc = 1;
        mdlDisp = 0;
        mdlErr = 0;
    endtask

    task automatic mdlApply(input bit rs, input int d);
        mdlEvt++;
        if (rs) begin
            mdlMem[mdlCur] = d[7:0];
            mdlCur = mdlInc ? (mdlCur + 1) % 32 : (mdlCur + 31) % 32;
        end else if (d >= 128) begin
            mdlCur = ((d / 64) % 2) * 16 + (d % 16);
        end else if (d >= 16) begin
            mdlCur = mdlCur;
        end else if (d >= 8) begin
            mdlDisp = ((d / 4) % 2) == 1;
        end else if (d >= 4) begin
            mdlInc = ((d / 2) % 2) == 1;
        end else if (d >= 2) begin
            mdlCur = 0;
        end else if (d == 1) begin
            mdlCur = 0;
            mdlInc = 1;
            for (int a = 0; a < 32; a++) mdlMem[a] = 8'h20;
        end
    endtask

    task automatic busWrite(input bit rs, input bit rw, input int d, input int gap);
        @(negedge iCLK);
        LCD_RS = rs;
        LCD_RW = rw;
        LCD_DATA = d[7:0];
        LCD_EN = 1'b1;
        repeat (3) @(negedge iCLK);
        LCD_EN = 1'b0;
        repeat (gap) @(negedge iCLK);
    endtask

    task automatic doWrite(input bit rs, input int d);
        busWrite(rs, 1'b0, d, (!rs && d == 1) ? CGAP : GAP);
        mdlApply(rs, d);
    endtask

    task automatic readAll();
        for (int a = 0; a < 32; a++) begin
            @(negedge iCLK);
            iRD_ADDR = 5'(a);
            @(negedge iCLK);
            rdVals[a] = oRD_CHAR;
        end
    endtask

    task automatic test_reset();
        #1 iRST_N = 1'b0;
        repeat (3) @(negedge iCLK);
        checks++;
        if ({oRD_CHAR, oCURSOR, oDISP_ON, oBUSY, oEVT, oEVT_RS, oEVT_DATA, oERR} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got chr=%h cur=%0d disp=%b busy=%b evt=%b rs=%b data=%h err=%b want all 0",
                     oRD_CHAR, oCURSOR, oDISP_ON, oBUSY, oEVT, oEVT_RS, oEVT_DATA, oERR);
        end
        iRST_N = 1'b1;
        mdlReset();
        repeat (5) @(negedge iCLK);
        checks++;
        if (oBUSY !== 1'b1) begin
            failures++;
            $display("FAIL init_busy: got %b want 1", oBUSY);
        end
        repeat (40) @(negedge iCLK);
        checks++;
        if (oBUSY !== 1'b0 || oCURSOR !== 5'd0 || oERR !== 1'b0) begin
            failures++;
            $display("FAIL init_done: got busy=%b cur=%0d err=%b want 0 0 0", oBUSY, oCURSOR, oERR);
        end
        readAll();
        for (int a = 0; a < 32; a++) begin
            checks++;
            if (rdVals[a] !== 8'h20) begin
                failures++;
                $display("FAIL init_fill[%0d]: got %h want 20", a, rdVals[a]);
            end
        end
    endtask

    task automatic test_sequence();
        int e0;
        e0 = evtCnt;
        doWrite(0, 'h38);
        doWrite(0, 'h0C);
        doWrite(0, 'h01);
        doWrite(0, 'h06);
        doWrite(0, 'h80);
        doWrite(1, 'h48);
        checks++;
        if (evtCnt - e0 !== 6) begin
            failures++;
            $display("FAIL seq_events: got %0d want 6", evtCnt - e0);
        end
        checks++;
        if (oCURSOR !== 5'd1 || oDISP_ON !== 1'b1) begin
            failures++;
            $display("FAIL seq_state: got cur=%0d disp=%b want 1 1", oCURSOR, oDISP_ON);
        end
        checks++;
        if (lastRs !== 1'b1 || lastData !== 8'h48) begin
            failures++;
            $display("FAIL seq_evt_data: got rs=%b data=%h want 1 48", lastRs, lastData);
        end
        readAll();
        checks++;
        if (rdVals[0] !== 8'h48) begin
            failures++;
            $display("FAIL seq_ddram0: got %h want 48", rdVals[0]);
        end
    endtask

    task automatic test_line2_rw();
        int e0;
        doWrite(0, 'hC0);
        doWrite(1, 'h41);
        checks++;
        if (oCURSOR !== 5'd17) begin
            failures++;
            $display("FAIL line2_cursor: got %0d want 17", oCURSOR);
        end
        e0 = evtCnt;
        busWrite(1, 1, 'h55, GAP);
        busWrite(0, 1, 'h01, GAP);
        checks++;
        if (evtCnt !== e0 || oCURSOR !== 5'd17 || oERR !== 1'b0 || oBUSY !== 1'b0) begin
            failures++;
            $display("FAIL rw_ignored: got evt+%0d cur=%0d err=%b busy=%b want +0 17 0 0",
                     evtCnt - e0, oCURSOR, oERR, oBUSY);
        end
        readAll();
        checks++;
        if (rdVals[16] !== 8'h41 || rdVals[17] !== 8'h20) begin
            failures++;
            $display("FAIL line2_ddram: got %h %h want 41 20", rdVals[16], rdVals[17]);
        end
    endtask

    task automatic test_wrap();
        doWrite(0, 'h80);
        doWrite(0, 'h04);
        doWrite(1, 'h5A);
        checks++;
        if (oCURSOR !== 5'd31) begin
            failures++;
            $display("FAIL wrap_down: got %0d want 31", oCURSOR);
        end
        doWrite(0, 'h06);
        doWrite(1, 'h33);
        checks++;
        if (oCURSOR !== 5'd0) begin
            failures++;
            $display("FAIL wrap_up: got %0d want 0", oCURSOR);
        end
        readAll();
        checks++;
        if (rdVals[0] !== 8'h5A || rdVals[31] !== 8'h33) begin
            failures++;
            $display("FAIL wrap_ddram: got %h %h want 5a 33", rdVals[0], rdVals[31]);
        end
    endtask

    task automatic test_random();
        int r;
        int d;
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                busWrite(1, 1, $urandom_range(0, 255), GAP);
            end else begin
                if (r < 50) begin
                    d = 256 + $urandom_range(0, 255);
                end else if (r < 55) begin
                    d = 1;
                end else if (r < 70) begin
                    d = 128 + $urandom_range(0, 127);
                end else if (r < 80) begin
                    d = 8 + $urandom_range(0, 7);
                end else if (r < 88) begin
                    d = 4 + $urandom_range(0, 3);
                end else begin
                    d = $urandom_range(0, 127);
                end
                doWrite(d >= 256, d % 256);
                checks++;
                if (lastRs !== (d >= 256) || lastData !== 8'(d % 256)) begin
                    failures++;
                    $display("FAIL rnd_evt[%0d]: got rs=%b data=%h want rs=%b data=%h",
                             n, lastRs, lastData, d >= 256, d % 256);
                end
            end
            checks++;
            if (oCURSOR !== 5'(mdlCur) || oDISP_ON !== mdlDisp || oERR !== mdlErr
                || evtCnt !== mdlEvt) begin
                failures++;
                $display("FAIL rnd_state[%0d]: got cur=%0d disp=%b err=%b evt=%0d want %0d %b %b %0d",
                         n, oCURSOR, oDISP_ON, oERR, evtCnt, mdlCur, mdlDisp, mdlErr, mdlEvt);
            end
        end
        readAll();
        for (int a = 0; a < 32; a++) begin
            checks++;
            if (rdVals[a] !== mdlMem[a]) begin
                failures++;
                $display("FAIL rnd_ddram[%0d]: got %h want %h", a, rdVals[a], mdlMem[a]);
            end
        end
    endtask

    task automatic test_busy_drop();
        doWrite(1, 'h6B);
        busWrite(0, 0, 'h01, 5);
        mdlApply(0, 1);
        busWrite(1, 0, 'h77, CGAP);
        mdlErr = 1;
        checks++;
        if (evtCnt !== mdlEvt || oERR !== 1'b1 || oCURSOR !== 5'd0) begin
            failures++;
            $display("FAIL busy_drop: got evt=%0d err=%b cur=%0d want %0d 1 0",
                     evtCnt, oERR, oCURSOR, mdlEvt);
        end
        readAll();
        for (int a = 0; a < 32; a++) begin
            checks++;
            if (rdVals[a] !== 8'h20) begin
                failures++;
                $display("FAIL clear_fill[%0d]: got %h want 20", a, rdVals[a]);
            end
        end
    endtask

    task automatic test_reset_mid();
        doWrite(0, 'h0F);
        doWrite(0, 'h85);
        doWrite(1, 'h39);
        busWrite(0, 0, 'h01, 3);
        @(negedge iCLK);
        iRST_N = 1'b0;
        #1;
        checks++;
        if ({oCURSOR, oDISP_ON, oBUSY, oEVT, oEVT_RS, oEVT_DATA, oERR, oRD_CHAR} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got cur=%0d disp=%b busy=%b evt=%b rs=%b data=%h err=%b chr=%h want all 0",
                     oCURSOR, oDISP_ON, oBUSY, oEVT, oEVT_RS, oEVT_DATA, oERR, oRD_CHAR);
        end
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        mdlReset();
        repeat (40) @(negedge iCLK);
        checks++;
        if (oBUSY !== 1'b0 || oERR !== 1'b0 || oCURSOR !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid_init: got busy=%b err=%b cur=%0d want 0 0 0", oBUSY, oERR, oCURSOR);
        end
        readAll();
        for (int a = 0; a < 32; a++) begin
            checks++;
            if (rdVals[a] !== 8'h20) begin
                failures++;
                $display("FAIL reset_mid_fill[%0d]: got %h want 20", a, rdVals[a]);
            end
        end
        doWrite(1, 'h44);
        checks++;
        if (oCURSOR !== 5'd1) begin
            failures++;
            $display("FAIL reset_mid_incdir: got %0d want 1", oCURSOR);
        end
    endtask

`ifdef LCD_RESP_BUSY_EN
    task automatic test_busy_window();
        int e0;
        @(negedge iCLK);
        iRST_N = 1'b0;
        @(negedge iCLK);
        iRST_N = 1'b1;
        mdlReset();
        repeat (40) @(negedge iCLK);
        e0 = evtCnt;
        busWrite(1, 0, 'h61, 14);
        busWrite(1, 0, 'h62, 150);
        checks++;
        if (evtCnt - e0 !== 1 || oERR !== 1'b1 || oCURSOR !== 5'd1) begin
            failures++;
            $display("FAIL busy_fast: got evt+%0d err=%b cur=%0d want +1 1 1", evtCnt - e0, oERR, oCURSOR);
        end
        @(negedge iCLK);
        iRST_N = 1'b0;
        @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (40) @(negedge iCLK);
        e0 = evtCnt;
        busWrite(1, 0, 'h61, 194);
        busWrite(1, 0, 'h62, 150);
        checks++;
        if (evtCnt - e0 !== 2 || oERR !== 1'b0 || oCURSOR !== 5'd2) begin
            failures++;
            $display("FAIL busy_slow: got evt+%0d err=%b cur=%0d want +2 0 2", evtCnt - e0, oERR, oCURSOR);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_line2_rw();
        test_wrap();
        test_random();
        test_busy_drop();
        test_reset_mid();
`ifdef LCD_RESP_BUSY_EN
        test_busy_window();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
